// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises raw sources, latches per-channel pending bits
// (edge or level), masks them with ENABLE and reports the highest-priority channel.
module irq_ctrl #(
  parameter int IRQ_CH      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] irq_in,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              ack,
  output logic [IRQ_CH-1:0] irq_out,
  output logic [4:0]        int_id,
  output logic              int_act
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][IRQ_CH-1:0]  sync_q, sync_d;
  logic [IRQ_CH-1:0]                   prev_q, prev_d;
  logic [IRQ_CH-1:0]                   pend_q, pend_d;
  logic [IRQ_CH-1:0]                   enable_q, enable_d;
  logic [IRQ_CH-1:0]                   mode_q, mode_d;
  logic [IRQ_CH-1:0]                   irq_out_q, irq_out_d;
  logic [31:0]                         rd_q, rd_d;

  logic [IRQ_CH-1:0] s, clr;
  logic [31:0]       rd_mux;
  logic              take, wr_en;
  logic              unused_wr;

  // Upper write-data bits are ignored when IRQ_CH < 32.
  assign unused_wr = ^wr_data;

  assign s     = sync_q[SYNC_STAGES-1];
  assign take  = (state_q == IDLE) && req;
  assign wr_en = take && we;
  assign clr   = (wr_en && addr == 2'd0) ? wr_data[IRQ_CH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (addr)
      2'd0: rd_mux[IRQ_CH-1:0] = pend_q;
      2'd1: rd_mux[IRQ_CH-1:0] = enable_q;
      2'd2: rd_mux[IRQ_CH-1:0] = mode_q;
      default: rd_mux[5:0] = {int_act, int_id};
    endcase
  end

  // Datapath next-state; an edge set in the same cycle as a W1C clear wins.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], irq_in};
    prev_d    = s;
    pend_d    = (mode_q & ((pend_q & ~clr) | (s & ~prev_q))) | (~mode_q & s);
    enable_d  = (wr_en && addr == 2'd1) ? wr_data[IRQ_CH-1:0] : enable_q;
    mode_d    = (wr_en && addr == 2'd2) ? wr_data[IRQ_CH-1:0] : mode_q;
    irq_out_d = pend_q & enable_q;
    rd_d      = (take && !we) ? rd_mux : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      mode_q    <= '1;
      irq_out_q <= '0;
      rd_q      <= '0;
    end else begin
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      irq_out_q <= irq_out_d;
      rd_q      <= rd_d;
    end
  end

  // Bus handshake FSM
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = req ? ACK : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack     = (state_q == ACK);
    rd_data = ack ? rd_q : '0;
  end

  always_comb begin
    irq_out = irq_out_q;
    int_act = |irq_out_q;
    int_id  = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--)
      if (irq_out_q[i]) int_id = 5'(i);
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (IRQ_CH=8, SYNC_STAGES=2).
module tb_irq_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic        req, we;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic [7:0]  irq_out;
  logic [4:0]  int_id;
  logic        int_act;

  int checks = 0;
  int errors = 0;
  logic [31:0] q;

  irq_ctrl #(.IRQ_CH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .req(req), .we(we), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .ack(ack), .irq_out(irq_out),
    .int_id(int_id), .int_act(int_act)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transfer: request sampled at the next edge, ack for exactly one cycle.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d,
                     output logic [31:0] rq);
    req = 1'b1; we = w; addr = a; wr_data = d;
    tick(1);
    chk("ack_hi", {31'b0, ack}, 32'd1);
    rq = rd_data;
    req = 1'b0; we = 1'b0; wr_data = '0;
    tick(1);
    chk("ack_lo", {31'b0, ack}, 32'd0);
    chk("rd_idle", rd_data, 32'd0);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    chk(tag, r, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic out_chk(input string tag, input logic [7:0] eo, input logic [4:0] eid,
                         input logic eact);
    chk({tag, "_irq_out"}, {24'b0, irq_out}, {24'b0, eo});
    chk({tag, "_int_id"}, {27'b0, int_id}, {27'b0, eid});
    chk({tag, "_int_act"}, {31'b0, int_act}, {31'b0, eact});
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; req = 1'b0; we = 1'b0; addr = '0; wr_data = '0;
    tick(3);
    // 1: reset state and register defaults
    chk("rst_ack", {31'b0, ack}, 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    out_chk("rst", 8'h00, 5'd0, 1'b0);
    reset = 1'b0;
    tick(1);
    rd(2'd0, 32'h0, "rd_pend0");
    rd(2'd1, 32'h0, "rd_en0");
    rd(2'd2, 32'h000000FF, "rd_mode0");
    rd(2'd3, 32'h0, "rd_stat0");

    // 2: single edge pulse on channel 3
    wr(2'd1, 32'h0000000C);
    irq_in[3] = 1'b1;
    tick(1);
    irq_in[3] = 1'b0;
    tick(2);
    chk("lat_early", {24'b0, irq_out}, 32'h0);
    tick(1);
    out_chk("ch3", 8'h08, 5'd3, 1'b1);
    rd(2'd3, 32'h00000023, "rd_stat3");
    wr(2'd0, 32'h00000008);
    out_chk("ch3_clr", 8'h00, 5'd0, 1'b0);
    rd(2'd0, 32'h0, "rd_pend_clr3");

    // 3: priority between channels 2 and 5
    irq_in = 8'h24;
    tick(1);
    irq_in = 8'h00;
    tick(5);
    rd(2'd0, 32'h00000024, "rd_pend25");
    wr(2'd1, 32'h000000FF);
    out_chk("pri25", 8'h24, 5'd2, 1'b1);
    wr(2'd0, 32'h00000004);
    out_chk("pri5", 8'h20, 5'd5, 1'b1);
    wr(2'd0, 32'h00000020);
    out_chk("pri_none", 8'h00, 5'd0, 1'b0);

    // 4: level channel 0 ignores W1C while the source is held
    wr(2'd2, 32'h000000FE);
    irq_in[0] = 1'b1;
    tick(4);
    out_chk("lvl0", 8'h01, 5'd0, 1'b1);
    rd(2'd0, 32'h00000001, "rd_pend_lvl");
    wr(2'd0, 32'h00000001);
    rd(2'd0, 32'h00000001, "rd_pend_lvl_w1c");
    irq_in[0] = 1'b0;
    tick(3);
    chk("lvl_fall_early", {24'b0, irq_out}, 32'h01);
    tick(1);
    chk("lvl_fall", {24'b0, irq_out}, 32'h00);
    rd(2'd0, 32'h0, "rd_pend_lvl_off");
    wr(2'd2, 32'h000000FF);
    rd(2'd0, 32'h0, "rd_pend_modesw");

    // 5: edge set and W1C on channel 4 land on the same edge
    irq_in[4] = 1'b1;
    tick(1);
    irq_in[4] = 1'b0;
    tick(1);
    wr(2'd0, 32'h00000010);
    rd(2'd0, 32'h00000010, "rd_pend_setwins");
    wr(2'd0, 32'h00000010);
    rd(2'd0, 32'h0, "rd_pend4_clr");

    // 6: reset in the ack cycle of an ENABLE write, req held through reset
    req = 1'b1; we = 1'b1; addr = 2'd1; wr_data = 32'h00000055;
    tick(1);
    chk("r6_ack", {31'b0, ack}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("r6_ack_rst", {31'b0, ack}, 32'd0);
    we = 1'b0; wr_data = '0;
    tick(1);
    chk("r6_ack_rst2", {31'b0, ack}, 32'd0);
    reset = 1'b0;
    tick(1);
    chk("r6_retry_ack", {31'b0, ack}, 32'd1);
    chk("r6_en_after_rst", rd_data, 32'h0);
    req = 1'b0;
    tick(1);
    chk("r6_ack_lo", {31'b0, ack}, 32'd0);
    rd(2'd2, 32'h000000FF, "r6_mode");
    out_chk("r6", 8'h00, 5'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
